// File: rtl/fetch_unit.sv
// PC/IR holder for the multi-cycle CPU: fetch on do_fetch, advance or branch on do_next, sticky halt.
// Optional retire counter is built only when FETCH_RETIRE_COUNTER_EN is defined.
module fetch_unit #(
  parameter int ADDR_WIDTH   = 8,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_SIZE  = 4,
  parameter int NUM_ALU_OPS  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int OPCODE_BEQ   = 8,
  parameter int OPCODE_BNE   = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   do_fetch,
  input  logic                   do_next,
  input  logic                   do_reset,
  input  logic                   do_halt,
  input  logic                   cmp_equal,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   is_alu_operation,
  output logic [2:0]             rd,
  output logic [2:0]             rs1,
  output logic [2:0]             rs2,
  output logic [7:0]             imm8,
  output logic [5:0]             imm6,
  output logic                   halted,
  output logic [15:0]            retired_count
);

  localparam logic [ADDR_WIDTH-1:0]  PC_RESET  = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [OPCODE_SIZE:0]   ALU_LIMIT = (OPCODE_SIZE+1)'(NUM_ALU_OPS);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ    = OPCODE_SIZE'(OPCODE_BEQ);
  localparam logic [OPCODE_SIZE-1:0] OP_BNE    = OPCODE_SIZE'(OPCODE_BNE);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   halted_q, halted_d;
  logic                   retire;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_off;

  assign opcode           = ir_q[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign is_alu_operation = ({1'b0, opcode} < ALU_LIMIT);
  assign rd               = ir_q[11:9];
  assign rs1              = ir_q[8:6];
  assign rs2              = ir_q[5:3];
  assign imm8             = ir_q[7:0];
  assign imm6             = ir_q[5:0];
  assign pc               = pc_q;
  assign imem_addr        = pc_q;
  assign halted           = halted_q;

  // Branch offset is relative to the branch's own address, not PC+1.
  assign branch_off   = {{(ADDR_WIDTH-6){imm6[5]}}, imm6};
  assign branch_taken = ((opcode == OP_BEQ) && cmp_equal) ||
                        ((opcode == OP_BNE) && !cmp_equal);

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    retire   = 1'b0;
    if (do_reset) begin
      pc_d     = PC_RESET;
      ir_d     = '0;
      halted_d = 1'b0;
    end else if (halted_q || do_halt) begin
      halted_d = 1'b1;
    end else if (do_fetch) begin
      ir_d = imem_data;
    end else if (do_next) begin
      retire = 1'b1;
      pc_d   = branch_taken ? (pc_q + branch_off) : (pc_q + 1'b1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_RETIRE_COUNTER_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (do_reset) begin
      count_d = '0;
    end else if (retire) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_count = '0;
`endif

endmodule
